pipe_hazard_control: RTL and testbench
======================================

// Module: pipe_hazard_control
// PURPOSE
//  Pipelined RV32I control unit. Decodes the ID-stage instruction and carries its controls through ID/EX, EX/MEM, MEM/WB.
//  Adds load-use stall, EX-stage branch/jump resolution with flush, operand forwarding selects and global memory stall.
//  Sits between the IF/ID register and the datapath stage registers.
// PARAMETERS
//  INSTR_WIDTH    32  instruction width
//  REG_ADDR_WIDTH 5   register index width
//  ALU_SEL_WIDTH  4   ALU op code width
//  FORWARD_EN     1   1: forwarding muxes used; 0: RAW hazards resolved by stalling
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   async active-low reset
//  instr_decode    in   32  instruction in IF/ID
//  id_valid        in   1   IF/ID holds a real instruction
//  br_eq, br_lt    in   1   EX-stage comparator results
//  mem_stall       in   1   data/instr memory wait; freezes whole pipe
//  id_imm_sel      out  3   ID imm type: 0 I, 1 S, 2 B, 3 U, 4 J (combinational)
//  stall_if_id     out  1   hold PC and IF/ID
//  flush_if_id     out  1   clear IF/ID at next edge
//  pc_sel          out  1   0 PC+4, 1 ALU target (EX redirect)
//  ex_a_sel        out  1   0 rs1, 1 PC
//  ex_b_sel        out  1   0 rs2, 1 imm
//  ex_alu_sel      out  4   R:{f7[5],f3}; IMM:{f3==5?i[30]:0,f3}; LUI 4'hF (pass B); else ADD 0
//  ex_br_unsign    out  1   BLTU/BGEU
//  ex_fwd_a/b      out  2   0 regfile, 1 EX/MEM result, 2 MEM/WB result
//  mem_write_en    out  1   store in MEM (valid-qualified)
//  mem_funct3      out  3   load/store size in MEM
//  wb_reg_write_en out  1   regfile write, never for rd=0
//  wb_sel          out  2   0 mem, 1 ALU, 2 PC+4
//  wb_rd           out  5   WB destination
//  illegal_instr   out  1   1-cycle pulse: valid unknown opcode in ID
// BEHAVIOUR
//  - Reset: every stage valid=0, all registered outputs 0; comb outputs 0 while IF/ID invalid.
//  - Decode: LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP_IMM,OP_R; others -> bubble + illegal_instr.
//  - Regfile is write-through; WB-vs-ID needs no stall.
//  - Latency: ID->EX->MEM->WB, 1 cycle each; controls register only with stage valid.
//  - Redirect: EX valid & (JAL | JALR | BRANCH taken): pc_sel=1, flush_if_id=1 same cycle;
//    ID/EX loads bubble at edge. Penalty 2 cycles.
//  - Taken: BEQ eq, BNE !eq, BLT/BLTU lt, BGE/BGEU !lt.
//  - Load-use: EX valid load, rd!=0, rd==used ID rs1/rs2 -> stall_if_id=1, ID/EX bubble, 1 cycle.
//  - FORWARD_EN=0: stall while EX or MEM rd (writing, !=0) matches used ID source; ex_fwd_* stay 0.
//  - Forwarding: MEM match beats WB match; rd=0 never forwards.
//  - Priority: mem_stall > redirect > RAW/load-use stall.
//  - mem_stall: all stage regs hold; stall_if_id=1; flush_if_id=0; pc_sel still reflects EX.
//  - Redirect plus load-use in the same cycle: flush only (wrong-path ID).
//  - Reset mid-op: all in-flight instructions dropped, no writes issued.
// TESTING
//  1 addi x1,x0,5 (00500093) -> WB 3 cycles later: wb_reg_write_en=1, wb_rd=1, wb_sel=1.
//  2 lw x2,0(x1) (0000A103) then add x3,x2,x1 (001101B3) -> one stall cycle;
//    add in EX: fwd_a=2, fwd_b=0.
//  3 addi x1 then sub x4,x3,x1 (40118233) -> ex_fwd_b=1, ex_alu_sel=4'h8, no stall.
//  4 beq x0,x0,8 (00000463), br_eq=1 -> pc_sel=1, flush_if_id=1; following 2 slots never write back.
//  5 mem_stall=1 for 3 cycles mid-stream -> all outputs frozen, no duplicate or lost writeback.
//  6 opcode 7'h7F valid -> illegal_instr 1 cycle, bubble; rst_n low mid-stream -> all outputs 0 async.

Source files
------------

// File: rtl/pipe_hazard_control.sv
// Pipelined RV32I control: ID decode, ID/EX -> EX/MEM -> MEM/WB control carry,
// load-use / RAW stalls, EX-stage redirect with flush, forwarding selects and global memory stall.
module pipe_hazard_control #(
   parameter int unsigned INSTR_WIDTH    = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned ALU_SEL_WIDTH  = 4,
   parameter bit          FORWARD_EN     = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [INSTR_WIDTH-1:0]    instr_decode,
   input  logic                      id_valid,
   input  logic                      br_eq,
   input  logic                      br_lt,
   input  logic                      mem_stall,
   output logic [2:0]                id_imm_sel,
   output logic                      stall_if_id,
   output logic                      flush_if_id,
   output logic                      pc_sel,
   output logic                      ex_a_sel,
   output logic                      ex_b_sel,
   output logic [ALU_SEL_WIDTH-1:0]  ex_alu_sel,
   output logic                      ex_br_unsign,
   output logic [1:0]                ex_fwd_a,
   output logic [1:0]                ex_fwd_b,
   output logic                      mem_write_en,
   output logic [2:0]                mem_funct3,
   output logic                      wb_reg_write_en,
   output logic [1:0]                wb_sel,
   output logic [REG_ADDR_WIDTH-1:0] wb_rd,
   output logic                      illegal_instr
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_R      = 7'b0110011;

   // A stage holding all-zero controls is a bubble.
   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      reg_write;
      logic                      mem_write;
      logic                      is_load;
      logic                      is_jal;
      logic                      is_jalr;
      logic                      is_branch;
      logic                      a_sel;
      logic                      b_sel;
      logic                      br_unsign;
      logic [2:0]                funct3;
      logic [ALU_SEL_WIDTH-1:0]  alu_sel;
      logic [1:0]                wb_sel;
   } ctrl_t;

   logic [6:0]                opcode;
   logic [2:0]                id_funct3;
   logic [REG_ADDR_WIDTH-1:0] id_rd, id_rs1, id_rs2;
   logic                      f7_b5;
   logic                      unused_bits;

   ctrl_t                     dec, ex;
   logic                      known, use_rs1, use_rs2;
   logic [1:0]                fwd_a_nx, fwd_b_nx;
   logic                      ex_hit, mem_hit, load_use, hazard, taken, redirect;

   logic [REG_ADDR_WIDTH-1:0] mem_rd;
   logic                      mem_reg_write;
   logic [1:0]                mem_wb_sel;

   assign opcode      = instr_decode[6:0];
   assign id_rd       = REG_ADDR_WIDTH'(instr_decode[11:7]);
   assign id_funct3   = instr_decode[14:12];
   assign id_rs1      = REG_ADDR_WIDTH'(instr_decode[19:15]);
   assign id_rs2      = REG_ADDR_WIDTH'(instr_decode[24:20]);
   assign f7_b5       = instr_decode[30];
   assign unused_bits = ^{instr_decode[INSTR_WIDTH-1:31], instr_decode[29:25]};

   // ID decode; everything stays zero while IF/ID is invalid
   always_comb begin
      dec        = '0;
      known      = 1'b0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      id_imm_sel = 3'd0;
      if (id_valid) begin
         case (opcode)
            OPC_LUI: begin
               known = 1'b1; dec.reg_write = 1'b1; dec.b_sel = 1'b1;
               dec.alu_sel = ALU_SEL_WIDTH'(4'hF); dec.wb_sel = 2'd1; id_imm_sel = 3'd3;
            end
            OPC_AUIPC: begin
               known = 1'b1; dec.reg_write = 1'b1; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
               dec.wb_sel = 2'd1; id_imm_sel = 3'd3;
            end
            OPC_JAL: begin
               known = 1'b1; dec.reg_write = 1'b1; dec.is_jal = 1'b1; dec.a_sel = 1'b1;
               dec.b_sel = 1'b1; dec.wb_sel = 2'd2; id_imm_sel = 3'd4;
            end
            OPC_JALR: begin
               known = 1'b1; dec.reg_write = 1'b1; dec.is_jalr = 1'b1; dec.b_sel = 1'b1;
               dec.wb_sel = 2'd2; use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
               known = 1'b1; dec.is_branch = 1'b1; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
               dec.br_unsign = id_funct3[1]; dec.funct3 = id_funct3;
               use_rs1 = 1'b1; use_rs2 = 1'b1; id_imm_sel = 3'd2;
            end
            OPC_LOAD: begin
               known = 1'b1; dec.reg_write = 1'b1; dec.is_load = 1'b1; dec.b_sel = 1'b1;
               dec.funct3 = id_funct3; dec.wb_sel = 2'd0; use_rs1 = 1'b1;
            end
            OPC_STORE: begin
               known = 1'b1; dec.mem_write = 1'b1; dec.b_sel = 1'b1; dec.funct3 = id_funct3;
               use_rs1 = 1'b1; use_rs2 = 1'b1; id_imm_sel = 3'd1;
            end
            OPC_IMM: begin
               known = 1'b1; dec.reg_write = 1'b1; dec.b_sel = 1'b1; dec.wb_sel = 2'd1;
               dec.alu_sel = ALU_SEL_WIDTH'({(id_funct3 == 3'd5) ? f7_b5 : 1'b0, id_funct3});
               use_rs1 = 1'b1;
            end
            OPC_R: begin
               known = 1'b1; dec.reg_write = 1'b1; dec.wb_sel = 2'd1;
               dec.alu_sel = ALU_SEL_WIDTH'({f7_b5, id_funct3});
               use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: ;
         endcase
      end
      dec.reg_write = dec.reg_write & (id_rd != '0);
      dec.rd        = dec.reg_write ? id_rd : '0;
   end

   assign ex_hit  = ex.reg_write &&
                    ((use_rs1 && id_rs1 == ex.rd) || (use_rs2 && id_rs2 == ex.rd));
   assign mem_hit = mem_reg_write &&
                    ((use_rs1 && id_rs1 == mem_rd) || (use_rs2 && id_rs2 == mem_rd));
   assign load_use = ex.is_load && ex_hit;
   assign hazard   = FORWARD_EN ? load_use : (ex_hit || mem_hit);

   always_comb begin
      taken = 1'b0;
      case (ex.funct3[2:1])
         2'b00:   taken = br_eq ^ ex.funct3[0];
         2'b10,
         2'b11:   taken = br_lt ^ ex.funct3[0];
         default: taken = 1'b0;
      endcase
   end

   assign redirect      = ex.is_jal || ex.is_jalr || (ex.is_branch && taken);
   assign pc_sel        = redirect;
   assign flush_if_id   = redirect && !mem_stall;
   assign stall_if_id   = mem_stall || (hazard && !redirect);
   assign illegal_instr = id_valid && !known && !mem_stall && !redirect;

   // Forward selects are resolved in ID against the producers that will sit in MEM/WB next cycle
   always_comb begin
      fwd_a_nx = 2'd0;
      fwd_b_nx = 2'd0;
      if (FORWARD_EN) begin
         if (use_rs1 && ex.reg_write && ex.rd == id_rs1)         fwd_a_nx = 2'd1;
         else if (use_rs1 && mem_reg_write && mem_rd == id_rs1)  fwd_a_nx = 2'd2;
         if (use_rs2 && ex.reg_write && ex.rd == id_rs2)         fwd_b_nx = 2'd1;
         else if (use_rs2 && mem_reg_write && mem_rd == id_rs2)  fwd_b_nx = 2'd2;
      end
   end

   // Stage registers; mem_stall freezes every stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex              <= '0;
         ex_fwd_a        <= 2'd0;
         ex_fwd_b        <= 2'd0;
         mem_rd          <= '0;
         mem_reg_write   <= 1'b0;
         mem_write_en    <= 1'b0;
         mem_funct3      <= 3'd0;
         mem_wb_sel      <= 2'd0;
         wb_rd           <= '0;
         wb_reg_write_en <= 1'b0;
         wb_sel          <= 2'd0;
      end else if (!mem_stall) begin
         if (redirect || hazard || !known) begin
            ex       <= '0;
            ex_fwd_a <= 2'd0;
            ex_fwd_b <= 2'd0;
         end else begin
            ex       <= dec;
            ex_fwd_a <= fwd_a_nx;
            ex_fwd_b <= fwd_b_nx;
         end
         mem_rd          <= ex.rd;
         mem_reg_write   <= ex.reg_write;
         mem_write_en    <= ex.mem_write;
         mem_funct3      <= (ex.is_load || ex.mem_write) ? ex.funct3 : 3'd0;
         mem_wb_sel      <= ex.wb_sel;
         wb_rd           <= mem_rd;
         wb_reg_write_en <= mem_reg_write;
         wb_sel          <= mem_wb_sel;
      end
   end

   assign ex_a_sel     = ex.a_sel;
   assign ex_b_sel     = ex.b_sel;
   assign ex_alu_sel   = ex.alu_sel;
   assign ex_br_unsign = ex.br_unsign;

endmodule

// File: tb/tb_pipe_hazard_control.sv
// Directed bench for pipe_hazard_control: decode, stalls, forwarding, redirect, mem_stall, reset.
module tb_pipe_hazard_control;

   localparam logic [31:0] ADDI_X1 = 32'h00500093;
   localparam logic [31:0] ADDI_X5 = 32'h00700293;
   localparam logic [31:0] ADDI_X6 = 32'h00800313;
   localparam logic [31:0] LW_X2   = 32'h0000A103;
   localparam logic [31:0] ADD_X3  = 32'h001101B3;
   localparam logic [31:0] SUB_X4  = 32'h40118233;
   localparam logic [31:0] SW_X1   = 32'h00102023;
   localparam logic [31:0] BEQ     = 32'h00000463;
   localparam logic [31:0] BNE     = 32'h00001463;
   localparam logic [31:0] BGE     = 32'h00005463;
   localparam logic [31:0] BLTU    = 32'h00006463;
   localparam logic [31:0] BGEU    = 32'h00007463;
   localparam logic [31:0] JAL_X1  = 32'h008000EF;
   localparam logic [31:0] ILLEGAL = 32'h0000007F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        id_valid, br_eq, br_lt, mem_stall;

   logic [2:0] id_imm_sel, mem_funct3;
   logic       stall_if_id, flush_if_id, pc_sel, ex_a_sel, ex_b_sel, ex_br_unsign;
   logic [3:0] ex_alu_sel;
   logic [1:0] ex_fwd_a, ex_fwd_b, wb_sel;
   logic       mem_write_en, wb_reg_write_en, illegal_instr;
   logic [4:0] wb_rd;

   logic [2:0] nf_imm_sel, nf_mem_funct3;
   logic       nf_stall, nf_flush, nf_pc_sel, nf_a_sel, nf_b_sel, nf_br_unsign;
   logic [3:0] nf_alu_sel;
   logic [1:0] nf_fwd_a, nf_fwd_b, nf_wb_sel;
   logic       nf_mem_write_en, nf_wb_we, nf_illegal;
   logic [4:0] nf_wb_rd;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_hazard_control dut (
      .clk(clk), .rst_n(rst_n), .instr_decode(instr), .id_valid(id_valid),
      .br_eq(br_eq), .br_lt(br_lt), .mem_stall(mem_stall),
      .id_imm_sel(id_imm_sel), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
      .pc_sel(pc_sel), .ex_a_sel(ex_a_sel), .ex_b_sel(ex_b_sel), .ex_alu_sel(ex_alu_sel),
      .ex_br_unsign(ex_br_unsign), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
      .mem_write_en(mem_write_en), .mem_funct3(mem_funct3),
      .wb_reg_write_en(wb_reg_write_en), .wb_sel(wb_sel), .wb_rd(wb_rd),
      .illegal_instr(illegal_instr)
   );

   pipe_hazard_control #(.FORWARD_EN(1'b0)) u_nf (
      .clk(clk), .rst_n(rst_n), .instr_decode(instr), .id_valid(id_valid),
      .br_eq(br_eq), .br_lt(br_lt), .mem_stall(mem_stall),
      .id_imm_sel(nf_imm_sel), .stall_if_id(nf_stall), .flush_if_id(nf_flush),
      .pc_sel(nf_pc_sel), .ex_a_sel(nf_a_sel), .ex_b_sel(nf_b_sel), .ex_alu_sel(nf_alu_sel),
      .ex_br_unsign(nf_br_unsign), .ex_fwd_a(nf_fwd_a), .ex_fwd_b(nf_fwd_b),
      .mem_write_en(nf_mem_write_en), .mem_funct3(nf_mem_funct3),
      .wb_reg_write_en(nf_wb_we), .wb_sel(nf_wb_sel), .wb_rd(nf_wb_rd),
      .illegal_instr(nf_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic [31:0] ins, input logic v, input logic eq,
                      input logic lt, input logic ms);
      instr = ins; id_valid = v; br_eq = eq; br_lt = lt; mem_stall = ms;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_imm"},    32'(id_imm_sel), 0);
      chk({tag, "_stall"},  32'(stall_if_id), 0);
      chk({tag, "_flush"},  32'(flush_if_id), 0);
      chk({tag, "_pcsel"},  32'(pc_sel), 0);
      chk({tag, "_asel"},   32'(ex_a_sel), 0);
      chk({tag, "_bsel"},   32'(ex_b_sel), 0);
      chk({tag, "_alu"},    32'(ex_alu_sel), 0);
      chk({tag, "_uns"},    32'(ex_br_unsign), 0);
      chk({tag, "_fwda"},   32'(ex_fwd_a), 0);
      chk({tag, "_fwdb"},   32'(ex_fwd_b), 0);
      chk({tag, "_memwe"},  32'(mem_write_en), 0);
      chk({tag, "_memf3"},  32'(mem_funct3), 0);
      chk({tag, "_wbwe"},   32'(wb_reg_write_en), 0);
      chk({tag, "_wbsel"},  32'(wb_sel), 0);
      chk({tag, "_wbrd"},   32'(wb_rd), 0);
      chk({tag, "_ill"},    32'(illegal_instr), 0);
   endtask

   task automatic br_case(input string tag, input logic [31:0] ins, input logic eq,
                          input logic lt, input logic exp_pc, input logic exp_uns);
      cyc(ins, 1'b1, 1'b0, 1'b0, 1'b0);
      chk({tag, "_imm"}, 32'(id_imm_sel), 2);
      tick();
      cyc(32'h0, 1'b0, eq, lt, 1'b0);
      chk({tag, "_pcsel"}, 32'(pc_sel), 32'(exp_pc));
      chk({tag, "_flush"}, 32'(flush_if_id), 32'(exp_pc));
      chk({tag, "_uns"},   32'(ex_br_unsign), 32'(exp_uns));
      tick();
      idle(3);
   endtask

   initial begin
      rst_n = 1'b0;
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      #10;
      check_all_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // addi x1 reaches WB three cycles after ID
      cyc(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t1_imm", 32'(id_imm_sel), 0);
      chk("t1_stall", 32'(stall_if_id), 0);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1_ex_bsel", 32'(ex_b_sel), 1);
      chk("t1_ex_asel", 32'(ex_a_sel), 0);
      chk("t1_ex_alu", 32'(ex_alu_sel), 0);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1_wbwe_early", 32'(wb_reg_write_en), 0);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1_wbwe", 32'(wb_reg_write_en), 1);
      chk("t1_wbrd", 32'(wb_rd), 1);
      chk("t1_wbsel", 32'(wb_sel), 1);
      tick();
      idle(3);

      // load-use: one stall then MEM/WB forward on rs1
      cyc(LW_X2, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t2_lw_stall", 32'(stall_if_id), 0);
      tick();
      cyc(ADD_X3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t2_stall", 32'(stall_if_id), 1);
      chk("t2_flush", 32'(flush_if_id), 0);
      chk("t2_nf_stall", 32'(nf_stall), 1);
      tick();
      cyc(ADD_X3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t2_stall_rel", 32'(stall_if_id), 0);
      chk("t2_bubble_bsel", 32'(ex_b_sel), 0);
      chk("t2_memf3", 32'(mem_funct3), 2);
      chk("t2_nf_stall_mem", 32'(nf_stall), 1);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_fwda", 32'(ex_fwd_a), 2);
      chk("t2_fwdb", 32'(ex_fwd_b), 0);
      chk("t2_ex_bsel", 32'(ex_b_sel), 0);
      chk("t2_wbrd_lw", 32'(wb_rd), 2);
      chk("t2_wbsel_lw", 32'(wb_sel), 0);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_wbwe_bubble", 32'(wb_reg_write_en), 0);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_wbrd_add", 32'(wb_rd), 3);
      tick();
      idle(3);

      // EX/MEM forward on rs2, no stall
      cyc(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      cyc(SUB_X4, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_stall", 32'(stall_if_id), 0);
      chk("t3_nf_stall", 32'(nf_stall), 1);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_fwdb", 32'(ex_fwd_b), 1);
      chk("t3_fwda", 32'(ex_fwd_a), 0);
      chk("t3_alu", 32'(ex_alu_sel), 32'h8);
      chk("t3_nf_fwdb", 32'(nf_fwd_b), 0);
      tick();
      idle(4);

      // store reaches MEM with write enable and size
      cyc(SW_X1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("sw_imm", 32'(id_imm_sel), 1);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sw_memwe", 32'(mem_write_en), 1);
      chk("sw_memf3", 32'(mem_funct3), 2);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sw_wbwe", 32'(wb_reg_write_en), 0);
      tick();
      idle(2);

      // beq taken: redirect, wrong-path slots never write back
      cyc(BEQ, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t4_imm", 32'(id_imm_sel), 2);
      tick();
      cyc(ADDI_X1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t4_pcsel", 32'(pc_sel), 1);
      chk("t4_flush", 32'(flush_if_id), 1);
      chk("t4_stall", 32'(stall_if_id), 0);
      chk("t4_asel", 32'(ex_a_sel), 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("t4_no_wb", 32'(wb_reg_write_en), 0);
         tick();
      end

      br_case("bne_nt", BNE, 1'b1, 1'b0, 1'b0, 1'b0);
      br_case("bltu_t", BLTU, 1'b0, 1'b1, 1'b1, 1'b1);
      br_case("bge_nt", BGE, 1'b0, 1'b1, 1'b0, 1'b0);
      br_case("bgeu_t", BGEU, 1'b0, 1'b0, 1'b1, 1'b1);

      // jal redirects unconditionally and writes PC+4
      cyc(JAL_X1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("jal_imm", 32'(id_imm_sel), 4);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("jal_pcsel", 32'(pc_sel), 1);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("jal_wbsel", 32'(wb_sel), 2);
      chk("jal_wbrd", 32'(wb_rd), 1);
      tick();
      idle(3);

      // mem_stall for 3 cycles while WB holds addi x1
      cyc(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      cyc(ADDI_X5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         cyc(ADDI_X6, 1'b1, 1'b0, 1'b0, 1'b1);
         chk("t5_stall", 32'(stall_if_id), 1);
         chk("t5_flush", 32'(flush_if_id), 0);
         chk("t5_wbwe", 32'(wb_reg_write_en), 1);
         chk("t5_wbrd", 32'(wb_rd), 1);
         tick();
      end
      cyc(ADDI_X6, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t5_rel_stall", 32'(stall_if_id), 0);
      chk("t5_rel_wbrd", 32'(wb_rd), 1);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_wbrd_x5", 32'(wb_rd), 5);
      chk("t5_wbwe_x5", 32'(wb_reg_write_en), 1);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_gap", 32'(wb_reg_write_en), 0);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_wbrd_x6", 32'(wb_rd), 6);
      chk("t5_wbwe_x6", 32'(wb_reg_write_en), 1);
      tick();
      idle(3);

      // illegal opcode: one-cycle pulse, bubble
      cyc(ILLEGAL, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t6_ill", 32'(illegal_instr), 1);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_ill_off", 32'(illegal_instr), 0);
      chk("t6_bubble_bsel", 32'(ex_b_sel), 0);
      tick();
      idle(1);
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_no_wb", 32'(wb_reg_write_en), 0);
      tick();

      // asynchronous reset with instructions in flight
      cyc(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      cyc(LW_X2, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_pre_bsel", 32'(ex_b_sel), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("arst");
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("arst_no_wb", 32'(wb_reg_write_en), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
